// File: rtl/encode_event_tx_pkg.sv
// Sync-word constants shared with the far-board decoder, plus FSM state type
// and the fixed-priority event picker used by the transmitter.
package encode_event_tx_pkg;

  localparam logic [15:0] SYNC_ENCODE_ZERO = 16'hECDE;
  localparam logic [15:0] SYNC_SCAN_BEGIN  = 16'h5A51;
  localparam logic [15:0] SYNC_SCAN_TEST   = 16'h5A53;
  localparam logic [15:0] SYNC_SCAN_END    = 16'h5A50;

  // Pending-bit indices; a higher index wins arbitration.
  localparam int EV_SCAN_BEGIN  = 0;
  localparam int EV_SCAN_TEST   = 1;
  localparam int EV_SCAN_END    = 2;
  localparam int EV_ENCODE_ZERO = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

  function automatic logic [3:0] pick_winner(input logic [3:0] pend);
    pick_winner = '0;
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) pick_winner = 4'b0001 << i;
    end
  endfunction

endpackage

// File: rtl/encode_event_tx_serial_tx.sv
// Word shifter with gated link clock: one word per load, followed by a silent gap.
//   state | meaning
//   IDLE  | link quiet, waiting for load
//   SHIFT | one group per bit-period on TX data, link clock toggling
//   GAP   | link clock and data held low for GAP_BITS bit-periods
module encode_event_tx_serial_tx
  import encode_event_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SERIAL_MODE = 1,
  parameter int CLK_DIV     = 4,
  parameter int GAP_BITS    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  word,
  output logic                   word_done,
  output logic                   busy_next,
  output logic                   tx_clk,
  output logic [SERIAL_MODE-1:0] tx_dout
);

  localparam int SHIFT_BITS = DATA_WIDTH / SERIAL_MODE;
  localparam int BIT_MAX    = (SHIFT_BITS > GAP_BITS) ? SHIFT_BITS : GAP_BITS;
  localparam int BW         = $clog2(BIT_MAX + 1);
  localparam int PW         = $clog2(2 * CLK_DIV);

  localparam logic [PW-1:0] PH_MAX     = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH    = PW'(CLK_DIV);
  localparam logic [BW-1:0] SHIFT_LOAD = BW'(SHIFT_BITS - 1);
  localparam logic [BW-1:0] GAP_LOAD   = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  tx_state_t               state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    tx_clk_d;
  logic [SERIAL_MODE-1:0]  tx_dout_d;
  logic                    period_end, word_end, start;

  assign period_end = (phase_q == '0);
  assign word_end   = period_end && (bit_q == '0);
  // Accepting at the last gap cycle keeps back-to-back words at exactly one slot.
  assign word_done  = (state_q == ST_IDLE) || ((state_q == ST_GAP) && word_end);
  assign start      = load && word_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_clk  <= 1'b0;
      tx_dout <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_clk  <= tx_clk_d;
      tx_dout <= tx_dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load) state_d = ST_SHIFT;
      ST_SHIFT: if (word_end) state_d = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (word_end) state_d = load ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (start) begin
      shreg_d = word;
      phase_d = PH_MAX;
      bit_d   = SHIFT_LOAD;
    end else if (state_q != ST_IDLE) begin
      phase_d = period_end ? PH_MAX : phase_q - PW'(1);
      if (period_end) begin
        if (bit_q == '0) begin
          bit_d   = GAP_LOAD;
          shreg_d = '0;
        end else begin
          bit_d = bit_q - BW'(1);
          if (state_q == ST_SHIFT) shreg_d = shreg_q << SERIAL_MODE;
        end
      end
    end
    tx_clk_d  = (state_d == ST_SHIFT) && (phase_d < PH_HIGH);
    tx_dout_d = (state_d == ST_SHIFT) ? shreg_d[DATA_WIDTH-1 -: SERIAL_MODE] : '0;
    busy_next = (state_d != ST_IDLE);
  end

endmodule

// File: rtl/encode_event_tx.sv
// Timing-event transmitter: latches event pulses as pending bits, arbitrates by
// fixed priority and hands the winning sync word to the serial shifter.
module encode_event_tx
  import encode_event_tx_pkg::*;
#(
  parameter real TCQ         = 0.1,
  parameter int  DATA_WIDTH  = 16,
  parameter int  SERIAL_MODE = 1,
  parameter int  CLK_DIV     = 4,
  parameter int  GAP_BITS    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   encode_zero_i,
  input  logic                   scan_begin_i,
  input  logic                   scan_test_i,
  input  logic                   scan_end_i,
  output logic                   busy_o,
  output logic                   drop_o,
  output logic                   TX_CLK,
  output logic [SERIAL_MODE-1:0] TX_DOUT
);

  if (TCQ < 0.0 || CLK_DIV < 1 || (DATA_WIDTH % SERIAL_MODE) != 0) begin : g_bad_param
    $error("encode_event_tx: illegal parameter combination");
  end

  logic [3:0]            pulse, pend_q, pend_d, win, clr, cancel;
  logic                  load, word_done, busy_next, drop_d, busy_d;
  logic [15:0]           word_sel;

  assign pulse = {encode_zero_i, scan_end_i, scan_test_i, scan_begin_i};
  assign load  = word_done && (|pend_q);
  assign win   = pick_winner(pend_q);
  assign clr   = load ? win : 4'b0000;

  // scan_end supersedes any scan_begin/scan_test still waiting to go out.
  assign cancel = {2'b00, scan_end_i, scan_end_i};

  // A pulse on the bit being loaded re-queues it rather than counting as a drop.
  assign pend_d = pulse | (pend_q & ~clr & ~cancel);
  assign drop_d = (|(pulse & pend_q & ~clr)) || (|(cancel & pend_q & ~clr));
  assign busy_d = (|pend_d) || busy_next;

  always_comb begin
    word_sel = SYNC_SCAN_BEGIN;
    if (win[EV_ENCODE_ZERO])     word_sel = SYNC_ENCODE_ZERO;
    else if (win[EV_SCAN_END])   word_sel = SYNC_SCAN_END;
    else if (win[EV_SCAN_TEST])  word_sel = SYNC_SCAN_TEST;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      busy_o <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_o <= busy_d;
      drop_o <= drop_d;
    end
  end

  encode_event_tx_serial_tx #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SERIAL_MODE (SERIAL_MODE),
    .CLK_DIV     (CLK_DIV),
    .GAP_BITS    (GAP_BITS)
  ) u_serial_tx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (load),
    .word      (DATA_WIDTH'(word_sel)),
    .word_done (word_done),
    .busy_next (busy_next),
    .tx_clk    (TX_CLK),
    .tx_dout   (TX_DOUT)
  );

endmodule

// File: tb/tb_encode_event_tx.sv
// Scoreboard bench: stimulus queues expected sync words, per-link monitors
// rebuild words from TX_CLK rising edges and compare.
module tb_encode_event_tx;

  logic clk_i;
  logic rst_i;
  logic ez, sb, st, se;
  logic ez4, sb4, st4, se4;
  logic busy, drop, tx_clk;
  logic [0:0] tx_dout;
  logic busy4, drop4, tx_clk4;
  logic [3:0] tx_dout4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words = 0, words4 = 0;
  int drops = 0, drops4 = 0;
  int first_rise4[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp4_q[$];

  encode_event_tx dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .encode_zero_i (ez), .scan_begin_i (sb), .scan_test_i (st), .scan_end_i (se),
    .busy_o (busy), .drop_o (drop), .TX_CLK (tx_clk), .TX_DOUT (tx_dout)
  );

  encode_event_tx #(.SERIAL_MODE(4), .CLK_DIV(1)) dut4 (
    .clk_i (clk_i), .rst_i (rst_i),
    .encode_zero_i (ez4), .scan_begin_i (sb4), .scan_test_i (st4), .scan_end_i (se4),
    .busy_o (busy4), .drop_o (drop4), .TX_CLK (tx_clk4), .TX_DOUT (tx_dout4)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // mask bits: [3] encode_zero, [2] scan_end, [1] scan_test, [0] scan_begin
  task automatic pulse(input logic [3:0] m, input logic [3:0] m4);
    {ez, se, st, sb}     = m;
    {ez4, se4, st4, sb4} = m4;
    tick(1);
    {ez, se, st, sb}     = 4'b0000;
    {ez4, se4, st4, sb4} = 4'b0000;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle4(input int limit);
    int n;
    n = 0;
    while (busy4 && n < limit) begin
      tick(1);
      n++;
    end
    chk("idle4_timeout", {31'd0, busy4}, 32'd0);
  endtask

  // Monitor for the 1-lane link
  initial begin
    logic prev;
    int n;
    logic [15:0] acc;
    logic [15:0] e;
    prev = 1'b0; n = 0; acc = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        n = 0;
        prev = 1'b0;
      end else begin
        if (tx_clk && !prev) begin
          acc = {acc[14:0], tx_dout};
          n++;
          if (n == 16) begin
            n = 0;
            words++;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_word actual %0h required none", acc);
            end else begin
              e = exp_q.pop_front();
              chk("word", {16'd0, acc}, {16'd0, e});
            end
          end
        end
        prev = tx_clk;
      end
    end
  end

  // Monitor for the 4-lane link
  initial begin
    logic prev;
    int n;
    logic [15:0] acc;
    logic [15:0] e;
    prev = 1'b0; n = 0; acc = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        n = 0;
        prev = 1'b0;
      end else begin
        if (tx_clk4 && !prev) begin
          acc = {acc[11:0], tx_dout4};
          n++;
          if (n == 1) first_rise4.push_back(cyc);
          if (n == 4) begin
            n = 0;
            words4++;
            if (exp4_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_word4 actual %0h required none", acc);
            end else begin
              e = exp4_q.pop_front();
              chk("word4", {16'd0, acc}, {16'd0, e});
            end
          end
        end
        prev = tx_clk4;
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (drop)  drops++;
    if (drop4) drops4++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, gap_bad;
    rst_i = 1'b1;
    {ez, se, st, sb} = 4'b0000;
    {ez4, se4, st4, sb4} = 4'b0000;
    tick(3);
    chk("rst_tx_clk",  {31'd0, tx_clk}, 32'd0);
    chk("rst_tx_dout", {31'd0, tx_dout}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_drop",    {31'd0, drop}, 32'd0);
    chk("rst_tx_clk4", {31'd0, tx_clk4}, 32'd0);
    rst_i = 1'b0;
    tick(2);

    // Single encode_zero: latency, clock phase, gap silence, busy duration
    exp_q.push_back(16'hECDE);
    pulse(4'b1000, 4'b0000);
    chk("busy_after_pulse", {31'd0, busy}, 32'd1);
    tick(1);
    chk("first_bit_msb", {31'd0, tx_dout}, 32'd1);
    chk("clk_low_t1", {31'd0, tx_clk}, 32'd0);
    tick(3);
    chk("clk_low_t4", {31'd0, tx_clk}, 32'd0);
    tick(1);
    chk("clk_rise_t5", {31'd0, tx_clk}, 32'd1);
    gap_bad = 0;
    for (int i = 6; i <= 160; i++) begin
      tick(1);
      if (i >= 129 && (tx_clk !== 1'b0 || tx_dout !== 1'b0)) gap_bad++;
    end
    chk("busy_t160", {31'd0, busy}, 32'd1);
    tick(1);
    chk("busy_t161", {31'd0, busy}, 32'd0);
    chk("gap_quiet", gap_bad, 32'd0);
    chk("words_t1", words, 32'd1);

    // Simultaneous encode_zero + scan_begin
    d0 = drops;
    exp_q.push_back(16'hECDE);
    exp_q.push_back(16'h5A51);
    pulse(4'b1001, 4'b0000);
    wait_idle(500);
    chk("drops_t2", drops - d0, 32'd0);
    chk("words_t2", words, 32'd3);

    // scan_test cancelled by scan_end during in-flight word
    d0 = drops;
    exp_q.push_back(16'hECDE);
    pulse(4'b1000, 4'b0000);
    tick(20);
    pulse(4'b0010, 4'b0000);
    tick(5);
    exp_q.push_back(16'h5A50);
    pulse(4'b0100, 4'b0000);
    wait_idle(500);
    chk("drops_t3", drops - d0, 32'd1);
    chk("words_t3", words, 32'd5);

    // encode_zero merged: two pulses during in-flight word
    d0 = drops;
    exp_q.push_back(16'hECDE);
    exp_q.push_back(16'hECDE);
    pulse(4'b1000, 4'b0000);
    tick(20);
    pulse(4'b1000, 4'b0000);
    tick(5);
    pulse(4'b1000, 4'b0000);
    wait_idle(500);
    chk("drops_t4", drops - d0, 32'd1);
    chk("words_t4", words, 32'd7);

    // 4-lane, CLK_DIV=1: nibble groups and 16-cycle slot
    exp4_q.push_back(16'h5A53);
    exp4_q.push_back(16'h5A53);
    pulse(4'b0000, 4'b0010);
    tick(5);
    pulse(4'b0000, 4'b0010);
    wait_idle4(100);
    chk("words4", words4, 32'd2);
    chk("drops4", drops4, 32'd0);
    if (first_rise4.size() >= 2)
      chk("slot4", first_rise4[1] - first_rise4[0], 32'd16);
    else
      chk("slot4_rises", first_rise4.size(), 32'd2);

    // Reset during bit 7 with scan_begin pending
    pulse(4'b1000, 4'b0000);
    tick(30);
    pulse(4'b0001, 4'b0000);
    tick(30);
    rst_i = 1'b1;
    tick(1);
    chk("midrst_tx_clk",  {31'd0, tx_clk}, 32'd0);
    chk("midrst_tx_dout", {31'd0, tx_dout}, 32'd0);
    chk("midrst_busy",    {31'd0, busy}, 32'd0);
    chk("midrst_drop",    {31'd0, drop}, 32'd0);
    rst_i = 1'b0;
    w0 = words;
    tick(400);
    chk("post_rst_words", words - w0, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_clk", {31'd0, tx_clk}, 32'd0);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("exp4_q_empty", exp4_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encode_event_tx.md
# encode_event_tx

Serializes timing events into 16-bit sync words on a clock+data serial link; this is the transmit end that drives the encoder/scan flag receiver on the far board. Event pulses (encoder zero, scan begin, scan test, scan end) are latched into per-event pending bits, arbitrated by fixed priority, and shifted out MSB-first over `SERIAL_MODE` data lanes with a generated, gated link clock. Sits between the local encoder/scan control logic and the board-to-board LVDS pins.

## Interface
- `TCQ`, 0.1, simulation clock-to-q delay
- `DATA_WIDTH`, 16, word width; must be divisible by `SERIAL_MODE`
- `SERIAL_MODE`, 1, data lanes (1/2/4/8)
- `CLK_DIV`, 4, clk_i cycles per TX_CLK half-period (>=1)
- `GAP_BITS`, 4, idle bit-periods forced after every word
- `clk_i`  in  1  system clock; one clock domain
- `rst_i`  in  1  synchronous, active-high reset
- `encode_zero_i`  in  1  one-cycle pulse: encoder zero event
- `scan_begin_i`  in  1  one-cycle pulse: scan begin
- `scan_test_i`  in  1  one-cycle pulse: scan test begin
- `scan_end_i`  in  1  one-cycle pulse: scan end
- `busy_o`  out  1  any pending bit set or FSM not IDLE
- `drop_o`  out  1  one-cycle pulse: an event was merged or cancelled
- `TX_CLK`  out  1  link clock, low when idle
- `TX_DOUT`  out  SERIAL_MODE  link data, 0 when idle

## Operation
- Words: encode zero `16'hECDE`, scan begin `16'h5A51`, scan test `16'h5A53`, scan end `16'h5A50`.
- Pending bits: set on input pulse. Pulse while own bit already set and not being cleared that cycle -> bit stays 1, `drop_o` pulses. Pulse in the cycle its bit is loaded -> bit stays set (re-queued), no drop.
- `scan_end_i` clears pending scan_begin/scan_test; if either was set, `drop_o` pulses.
- Priority: encode_zero > scan_end > scan_test > scan_begin.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: any pending -> load winner word into shift register, clear its bit, -> SHIFT.
  - SHIFT: `DATA_WIDTH/SERIAL_MODE` bit-periods; then -> GAP.
  - GAP: `GAP_BITS` bit-periods, TX_CLK low, TX_DOUT 0; then -> IDLE.
- Bit period = 2*CLK_DIV cycles: TX_CLK low for first CLK_DIV, high for second. TX_DOUT changes only at bit-period start (TX_CLK falling/low); receiver samples on TX_CLK rising.
- Lane mapping: TX_DOUT = shift_reg[DATA_WIDTH-1 -: SERIAL_MODE]; shift left by SERIAL_MODE per bit-period. Lane SERIAL_MODE-1 carries the MSB of each group.
- Word boundary is defined solely by TX_CLK inactivity (GAP).

## Timing
- All outputs registered. Reset values: TX_CLK 0, TX_DOUT 0, busy_o 0, drop_o 0, pending 0, state IDLE.
- Pulse sampled at edge t -> pending at t+1 -> load at edge t+1 (IDLE) -> first data group on TX_DOUT after t+1, TX_CLK rises after edge t+1+CLK_DIV.
- Word slot = (DATA_WIDTH/SERIAL_MODE + GAP_BITS)*2*CLK_DIV cycles; defaults: 128 + 32 = 160 cycles.
- Back-to-back: next word loads the cycle FSM returns to IDLE (no extra bubble beyond GAP).
- `rst_i` mid-word: outputs forced to reset values next edge; truncated word is followed by clock silence, receiver discards it.
- `busy_o` high from cycle after first pulse until IDLE with no pending.

## Structure
- Shared package/header `encode_sync_defs`: the four sync-word constants, shared with the receive-side decoder.
- Sub-module `serial_tx`: parameterized shifter + TX_CLK divider + bit/gap counters, with load/word_done handshake. `encode_event_tx` holds pending bits, arbitration, drop logic.

## Test plan
- Reset, single `encode_zero_i` pulse, defaults -> TX_DOUT MSB-first `1110110011011110` sampled on 16 TX_CLK rising edges, then 32 cycles idle; busy_o low after 160 cycles.
- `scan_begin_i` and `encode_zero_i` same cycle -> `ECDE` sent first, then `5A51`; no drop_o.
- `scan_test_i` then `scan_end_i` while `ECDE` shifting -> scan_test cancelled, drop_o one pulse, only `5A50` sent after `ECDE`.
- `encode_zero_i` pulsed twice during an in-flight word -> one drop_o pulse, exactly one extra `ECDE` sent.
- SERIAL_MODE=4, CLK_DIV=1: `5A53` -> 4 rising edges carrying 4'h5, 4'hA, 4'h5, 4'h3; slot 16 cycles.
- `rst_i` asserted at bit 7 of a word -> next edge TX_CLK=0, TX_DOUT=0, busy_o=0, pending cleared; no further words.
